// File: rtl/dma_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dma_pkg : shared widths and FSM state encoding for dma_copy      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package dma_pkg;

  localparam int c_ADDR_W = 32;
  localparam int c_DATA_W = 32;
  localparam int c_LEN_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } dma_state_t;

endpackage : dma_pkg
`default_nettype wire

// File: rtl/dma_addr_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dma_addr_gen : source/destination pointers and word counter      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module dma_addr_gen
  import dma_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W,
  parameter int LEN_W  = c_LEN_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] src_ptr,
  output logic [ADDR_W-1:0] dst_ptr,
  output logic              last
);

  logic [ADDR_W-1:0] r_src_ptr;
  logic [ADDR_W-1:0] r_dst_ptr;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  w_cnt_next;

  assign w_cnt_next = r_cnt + LEN_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_src_ptr <= '0;
      r_dst_ptr <= '0;
      r_cnt     <= '0;
      r_len     <= '0;
    end else if (load) begin
      r_src_ptr <= src;
      r_dst_ptr <= dst;
      r_cnt     <= '0;
      r_len     <= len;
    end else if (step) begin
      // Pointers wrap naturally at the top of the address space.
      r_src_ptr <= r_src_ptr + ADDR_W'(1);
      r_dst_ptr <= r_dst_ptr + ADDR_W'(1);
      r_cnt     <= w_cnt_next;
    end
  end

  assign src_ptr = r_src_ptr;
  assign dst_ptr = r_dst_ptr;
  // True during the WRITE of the final word.
  assign last    = (w_cnt_next == r_len);

endmodule : dma_addr_gen
`default_nettype wire

// File: rtl/dma_copy.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dma_copy : word-by-word memory copy engine (READ/LATCH/WRITE)    |
// | Optional running checksum output: DMA_COPY_CHECKSUM_EN           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module dma_copy
  import dma_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W,
  parameter int DATA_W = c_DATA_W,
  parameter int LEN_W  = c_LEN_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMA_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  dma_state_t        r_state;
  dma_state_t        w_state_next;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] w_src_ptr;
  logic [ADDR_W-1:0] w_dst_ptr;
  logic              w_last;
  logic              w_load;
  logic              w_step;

  assign w_load = (r_state == S_IDLE) && start;
  assign w_step = (r_state == S_WRITE);

  dma_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clock   (clock),
    .reset   (reset),
    .load    (w_load),
    .step    (w_step),
    .src     (src),
    .dst     (dst),
    .len     (len),
    .src_ptr (w_src_ptr),
    .dst_ptr (w_dst_ptr),
    .last    (w_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = (len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ:  w_state_next = S_LATCH;
      S_LATCH: w_state_next = S_WRITE;
      S_WRITE: w_state_next = w_last ? S_DONE : S_READ;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Strobes are masked by reset so an in-flight word is never committed.
  always_comb begin
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      S_READ: begin
        if (!reset) begin
          mem_read = 1'b1;
          mem_addr = w_src_ptr;
        end
      end
      S_WRITE: begin
        if (!reset) begin
          mem_write = 1'b1;
          mem_addr  = w_dst_ptr;
          mem_wdata = r_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_data <= '0;
    end else if (r_state == S_LATCH) begin
      r_data <= mem_rdata;
    end
  end

`ifdef DMA_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (w_load) begin
      r_checksum <= '0;
    end else if (r_state == S_LATCH) begin
      r_checksum <= r_checksum + mem_rdata;
    end
  end

  assign checksum = r_checksum;
`endif

endmodule : dma_copy
`default_nettype wire

// File: tb/tb_dma_copy.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dma_copy : directed table-driven bench for dma_copy           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_dma_copy;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src = '0;
  logic [31:0] dst = '0;
  logic [15:0] len = '0;
  logic        busy;
  logic        done;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
`ifdef DMA_COPY_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  dma_copy dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef DMA_COPY_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clock = ~clock;

  // Memory model: 256 words indexed by the low address byte, registered read.
  logic [31:0] mem [256];
  logic [31:0] rd_log [64];
  logic        preload = 1'b0;
  int          rd_n = 0;
  int          wr_n = 0;
  int          both_n = 0;
  int          done_n = 0;

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      mem[0]     <= 32'd20123;
      mem[1]     <= 32'd18833;
      mem[2]     <= 32'd39041;
      mem[3]     <= 32'hDEADBEEF;
      mem[4]     <= 32'h12345678;
      mem[8'h20] <= 32'h0000000A;
      mem[8'h21] <= 32'h0000000B;
      mem[8'h22] <= 32'h0000000C;
      mem[8'hFF] <= 32'h00000055;
    end else begin
      if (mem_read) begin
        mem_rdata         <= mem[mem_addr[7:0]];
        rd_log[rd_n % 64] <= mem_addr;
        rd_n              <= rd_n + 1;
      end
      if (mem_write) begin
        mem[mem_addr[7:0]] <= mem_wdata;
        wr_n               <= wr_n + 1;
      end
    end
  end

  always @(negedge clock) begin
    if (mem_read && mem_write) both_n <= both_n + 1;
    if (done) done_n <= done_n + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_preload();
    @(negedge clock);
    preload = 1'b1;
    @(negedge clock);
    preload = 1'b0;
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    int          poke;
    int          exp_lat;
    int          exp_wr;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] exp_sum;
  } vec_t;

  task automatic run_xfer(input vec_t v);
    int          wr0;
    int          rd0;
    int          lat;
    int          bc;
    logic [31:0] exp_d [3];
    exp_d[0] = v.d0;
    exp_d[1] = v.d1;
    exp_d[2] = v.d2;
    do_preload();
    wr0 = wr_n;
    rd0 = rd_n;
    lat = 0;
    bc  = 0;
    src = v.src;
    dst = v.dst;
    len = v.len;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    src = 32'h77;
    dst = 32'h88;
    len = 16'd5;
    for (int c = 1; c <= 200; c++) begin
      if (c > 1) @(negedge clock);
      if (v.poke != 0 && c == v.poke) begin
        start = 1'b1;
        src = 32'd3;
        dst = 32'd60;
        len = 16'd1;
      end else begin
        start = 1'b0;
      end
      if (busy) bc++;
      if (done) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    chk("done_latency", 64'(lat), 64'(v.exp_lat));
    chk("busy_cycles", 64'(bc), 64'(v.exp_lat));
    @(negedge clock);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_after_done", 64'(busy), 64'd0);
    chk("write_count", 64'(wr_n - wr0), 64'(v.exp_wr));
    chk("read_count", 64'(rd_n - rd0), 64'(v.exp_wr));
    for (int i = 0; i < 3; i++) begin
      if (i < v.exp_wr) chk("dest_word", 64'(mem[8'(v.dst + 32'(i))]), 64'(exp_d[i]));
    end
    if (v.exp_wr == 0) chk("dest_untouched", 64'(mem[v.dst[7:0]]), 64'd0);
`ifdef DMA_COPY_CHECKSUM_EN
    chk("checksum", 64'(checksum), 64'(v.exp_sum));
`endif
  endtask

  vec_t vecs [5];

  initial begin
    int          base;
    int          wr0;
    int          dn0;
    vec_t        wv;

    //        src         dst         len poke lat wr  d0            d1            d2            sum
    vecs[0] = '{32'h0,     32'd100,    16'd3, 0, 10, 3, 32'd20123,    32'd18833,    32'd39041,    32'd77997};
    vecs[1] = '{32'h0,     32'd200,    16'd0, 0,  1, 0, 32'd0,        32'd0,        32'd0,        32'd0};
    vecs[2] = '{32'h3,     32'd50,     16'd2, 0,  7, 2, 32'hDEADBEEF, 32'h12345678, 32'd0,        32'hF0E21567};
    vecs[3] = '{32'h20,    32'h21,     16'd3, 0, 10, 3, 32'hA,        32'hA,        32'hA,        32'h1E};
    vecs[4] = '{32'h0,     32'd100,    16'd3, 4, 10, 3, 32'd20123,    32'd18833,    32'd39041,    32'd77997};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_read", 64'(mem_read), 64'd0);
    chk("rst_write", 64'(mem_write), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
`ifdef DMA_COPY_CHECKSUM_EN
    chk("rst_checksum", 64'(checksum), 64'd0);
`endif

    for (int k = 0; k < 5; k++) run_xfer(vecs[k]);

    // Source address wraps from all-ones to zero on the second read.
    wv = '{32'hFFFFFFFF, 32'h10, 16'd2, 0, 7, 2, 32'h55, 32'd20123, 32'd0, 32'd20208};
    base = rd_n;
    run_xfer(wv);
    chk("wrap_rd0_addr", 64'(rd_log[base % 64]), 64'hFFFFFFFF);
    chk("wrap_rd1_addr", 64'(rd_log[(base + 1) % 64]), 64'h0);

    // Reset during the second WRITE of a four-word copy.
    do_preload();
    wr0 = wr_n;
    dn0 = done_n;
    src = 32'h0;
    dst = 32'd100;
    len = 16'd4;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    chk("second_write_live", 64'(mem_write), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_read", 64'(mem_read), 64'd0);
    chk("abort_write", 64'(mem_write), 64'd0);
    chk("abort_addr", 64'(mem_addr), 64'd0);
    chk("abort_wdata", 64'(mem_wdata), 64'd0);
`ifdef DMA_COPY_CHECKSUM_EN
    chk("abort_checksum", 64'(checksum), 64'd0);
`endif
    repeat (15) @(negedge clock);
    chk("abort_write_count", 64'(wr_n - wr0), 64'd1);
    chk("abort_word0", 64'(mem[100]), 64'd20123);
    chk("abort_word1", 64'(mem[101]), 64'd0);
    chk("abort_no_done", 64'(done_n - dn0), 64'd0);
    chk("abort_stays_idle", 64'(busy), 64'd0);

    chk("strobes_exclusive", 64'(both_n), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule : tb_dma_copy
`default_nettype wire
